// File: rtl/iic_pkg.sv
// Shared definitions for the EEPROM sequencer and the iic master it drives:
// sequencer states, wait-budget derivations and 24LC64 device constants.
package iic_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WR_REQ,
    ST_WR_TXN,
    ST_WR_TWC,
    ST_RD_REQ,
    ST_RD_TXN,
    ST_RD_CHK,
    ST_FIN
  } seq_state_t;

  localparam logic [6:0] EEPROM_DEV_ADD   = 7'b1010011;
  localparam int         EEPROM_PAGE_SIZE = 32;

  // 50 SCL periods per transaction; divide first so the product stays in int range.
  function automatic int txn_wait(input int sys_clk, input int iic_scl);
    return (sys_clk / iic_scl) * 50;
  endfunction

  // 5 ms internal write cycle.
  function automatic int twr_wait(input int sys_clk);
    return sys_clk / 200;
  endfunction

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/wait_timer.sv
// Loadable down-counter; tc_o is high during the last cycle of a loaded count
// (a load of V gives V cycles with tc_o on the V-th). A load of 0 never terminates.
module wait_timer #(
  parameter int W = 18
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         load_i,
  input  logic [W-1:0] val_i,
  output logic         tc_o
);

  logic [W-1:0] cnt_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else if (load_i) begin
      cnt_q <= val_i;
    end else if (cnt_q != '0) begin
      cnt_q <= cnt_q - 1'b1;
    end
  end

  assign tc_o = (cnt_q == W'(1));

endmodule

// File: rtl/eeprom_rw_seq.sv
// Writes NUM_BYTES bytes (seed+idx) to the EEPROM through the iic master, reads
// them back and counts mismatches. Transactions are paced by fixed cycle budgets.
module eeprom_rw_seq
  import iic_pkg::*;
#(
  parameter int          SYS_CLK   = 50_000_000,
  parameter int          IIC_SCL   = 250_000,
  parameter int          NUM_BYTES = 8,
  parameter logic [15:0] BASE_ADD  = 16'h0000,
  parameter int          TXN_WAIT  = txn_wait(SYS_CLK, IIC_SCL),
  parameter int          TWR_WAIT  = twr_wait(SYS_CLK)
) (
  input  logic        sys_clk,
  input  logic        sys_rst,
  input  logic        start,
  input  logic [7:0]  seed,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic [8:0]  err_cnt,
  output logic [7:0]  rd_byte,
  output logic        rd_valid,
  output logic        iic_add_bit,
  output logic        iic_wr_en,
  output logic        iic_rd_en,
  output logic [15:0] iic_word_add,
  output logic [7:0]  iic_wr_data,
  input  logic [7:0]  iic_rd_data
);

  localparam int TW = $clog2(max2(TXN_WAIT, TWR_WAIT) + 1);
  localparam int IW = (NUM_BYTES > 1) ? $clog2(NUM_BYTES) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(NUM_BYTES - 1);

  seq_state_t    state_q;
  logic [IW-1:0] idx_q;
  logic [7:0]    seed_q;
  logic          busy_q, done_q, pass_q, rd_valid_q, wr_en_q, rd_en_q;
  logic [8:0]    err_cnt_q;
  logic [7:0]    rd_byte_q, wr_data_q;
  logic [15:0]   word_add_q;

  logic          tmr_load, tmr_tc;
  logic [TW-1:0] tmr_val;
  logic [IW-1:0] idx_nxt;
  logic [7:0]    exp_byte;

  assign idx_nxt  = idx_q + 1'b1;
  assign exp_byte = seed_q + 8'(idx_q);

  // The request cycle itself is the first cycle of the TXN_WAIT budget.
  always_comb begin
    tmr_load = 1'b0;
    tmr_val  = '0;
    case (state_q)
      ST_WR_REQ, ST_RD_REQ: begin
        tmr_load = 1'b1;
        tmr_val  = TW'(TXN_WAIT - 1);
      end
      ST_WR_TXN: begin
        if (tmr_tc) begin
          tmr_load = 1'b1;
          tmr_val  = TW'(TWR_WAIT);
        end
      end
      default: ;
    endcase
  end

  wait_timer #(.W(TW)) u_wait_timer (
    .clk_i  (sys_clk),
    .rst_i  (sys_rst),
    .load_i (tmr_load),
    .val_i  (tmr_val),
    .tc_o   (tmr_tc)
  );

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state_q    <= ST_IDLE;
      idx_q      <= '0;
      seed_q     <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      pass_q     <= 1'b0;
      rd_valid_q <= 1'b0;
      wr_en_q    <= 1'b0;
      rd_en_q    <= 1'b0;
      err_cnt_q  <= '0;
      rd_byte_q  <= '0;
      wr_data_q  <= '0;
      word_add_q <= '0;
    end else begin
      wr_en_q    <= 1'b0;
      rd_en_q    <= 1'b0;
      rd_valid_q <= 1'b0;
      done_q     <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            seed_q     <= seed;
            idx_q      <= '0;
            err_cnt_q  <= '0;
            pass_q     <= 1'b0;
            busy_q     <= 1'b1;
            wr_en_q    <= 1'b1;
            word_add_q <= BASE_ADD;
            wr_data_q  <= seed;
            state_q    <= ST_WR_REQ;
          end
        end
        ST_WR_REQ: state_q <= ST_WR_TXN;
        ST_WR_TXN: if (tmr_tc) state_q <= ST_WR_TWC;
        ST_WR_TWC: begin
          if (tmr_tc) begin
            if (idx_q == LAST_IDX) begin
              idx_q      <= '0;
              rd_en_q    <= 1'b1;
              word_add_q <= BASE_ADD;
              state_q    <= ST_RD_REQ;
            end else begin
              idx_q      <= idx_nxt;
              wr_en_q    <= 1'b1;
              word_add_q <= BASE_ADD + 16'(idx_nxt);
              wr_data_q  <= seed_q + 8'(idx_nxt);
              state_q    <= ST_WR_REQ;
            end
          end
        end
        ST_RD_REQ: state_q <= ST_RD_TXN;
        ST_RD_TXN: begin
          // Readback is sampled on the last edge of the budget so RD_CHK shows it.
          if (tmr_tc) begin
            rd_byte_q  <= iic_rd_data;
            rd_valid_q <= 1'b1;
            if (iic_rd_data != exp_byte) err_cnt_q <= err_cnt_q + 9'd1;
            state_q    <= ST_RD_CHK;
          end
        end
        ST_RD_CHK: begin
          if (idx_q == LAST_IDX) begin
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
            pass_q  <= (err_cnt_q == '0);
            state_q <= ST_FIN;
          end else begin
            idx_q      <= idx_nxt;
            rd_en_q    <= 1'b1;
            word_add_q <= BASE_ADD + 16'(idx_nxt);
            state_q    <= ST_RD_REQ;
          end
        end
        ST_FIN:  state_q <= ST_IDLE;
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign busy         = busy_q;
  assign done         = done_q;
  assign pass         = pass_q;
  assign err_cnt      = err_cnt_q;
  assign rd_byte      = rd_byte_q;
  assign rd_valid     = rd_valid_q;
  assign iic_add_bit  = 1'b1;
  assign iic_wr_en    = wr_en_q;
  assign iic_rd_en    = rd_en_q;
  assign iic_word_add = word_add_q;
  assign iic_wr_data  = wr_data_q;

endmodule

// File: tb/tb_eeprom_rw_seq.sv
// Bench for eeprom_rw_seq: a behavioural EEPROM answers the enable pulses, and
// each run is checked against write/read lists and cycle counts derived from the rules.
module tb_eeprom_rw_seq;

  localparam int          N    = 4;
  localparam int          T    = 6;
  localparam int          W    = 4;
  localparam logic [15:0] BASE = 16'hFFFE;
  localparam int          RUN_LEN = N * (2 * T + W + 1);

  logic        sys_clk = 1'b0;
  logic        sys_rst = 1'b1;
  logic        start   = 1'b0;
  logic [7:0]  seed    = 8'h00;
  logic [7:0]  iic_rd_data = 8'h00;
  logic        busy, done, pass, rd_valid, iic_add_bit, iic_wr_en, iic_rd_en;
  logic [8:0]  err_cnt;
  logic [7:0]  rd_byte, iic_wr_data;
  logic [15:0] iic_word_add;

  eeprom_rw_seq #(
    .NUM_BYTES (N),
    .BASE_ADD  (BASE),
    .TXN_WAIT  (T),
    .TWR_WAIT  (W)
  ) dut (
    .sys_clk      (sys_clk),
    .sys_rst      (sys_rst),
    .start        (start),
    .seed         (seed),
    .busy         (busy),
    .done         (done),
    .pass         (pass),
    .err_cnt      (err_cnt),
    .rd_byte      (rd_byte),
    .rd_valid     (rd_valid),
    .iic_add_bit  (iic_add_bit),
    .iic_wr_en    (iic_wr_en),
    .iic_rd_en    (iic_rd_en),
    .iic_word_add (iic_word_add),
    .iic_wr_data  (iic_wr_data),
    .iic_rd_data  (iic_rd_data)
  );

  always #5 sys_clk = ~sys_clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  logic rst_seen = 1'b1;
  always @(posedge sys_clk) begin
    cyc      <= cyc + 1;
    rst_seen <= sys_rst;
  end

  // Behavioural EEPROM plus event log.
  logic [7:0]  mem [logic [15:0]];
  bit          wp = 1'b0;
  logic [7:0]  flip [N];
  int          wr_cyc_q[$], rd_cyc_q[$], rv_cyc_q[$], done_cyc_q[$];
  logic [15:0] wr_add_q[$], rd_add_q[$];
  logic [7:0]  wr_dat_q[$], rv_byte_q[$];
  int          viol = 0;
  int          rd_pend = 0;
  logic [7:0]  rd_val = 8'h00;
  logic [15:0] prev_add = 16'h0;
  logic [7:0]  prev_wd = 8'h0;

  always @(negedge sys_clk) begin
    #1;
    if (!rst_seen) begin
      if (iic_wr_en && iic_rd_en) viol++;
      if (!(iic_wr_en || iic_rd_en) && (iic_word_add !== prev_add || iic_wr_data !== prev_wd)) viol++;
      if (iic_add_bit !== 1'b1) viol++;
    end
    prev_add = iic_word_add;
    prev_wd  = iic_wr_data;
    if (iic_wr_en) begin
      wr_cyc_q.push_back(cyc);
      wr_add_q.push_back(iic_word_add);
      wr_dat_q.push_back(iic_wr_data);
      if (!wp) mem[iic_word_add] = iic_wr_data;
    end
    if (iic_rd_en) begin
      rd_val = (mem.exists(iic_word_add) ? mem[iic_word_add] : 8'hFF) ^ flip[rd_cyc_q.size() % N];
      rd_cyc_q.push_back(cyc);
      rd_add_q.push_back(iic_word_add);
      iic_rd_data = ~rd_val;            // garbage until late in the transaction
      rd_pend = T - 2;
    end else if (rd_pend > 0) begin
      rd_pend--;
      if (rd_pend == 0) iic_rd_data = rd_val;
    end
    if (rd_valid) begin
      rv_cyc_q.push_back(cyc);
      rv_byte_q.push_back(rd_byte);
    end
    if (done) done_cyc_q.push_back(cyc);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clear_log();
    wr_cyc_q.delete(); wr_add_q.delete(); wr_dat_q.delete();
    rd_cyc_q.delete(); rd_add_q.delete();
    rv_cyc_q.delete(); rv_byte_q.delete(); done_cyc_q.delete();
    viol = 0;
  endtask

  task automatic check_idle_outputs(input string tag);
    chk({tag, "_busy"},     32'(busy), 0);
    chk({tag, "_done"},     32'(done), 0);
    chk({tag, "_pass"},     32'(pass), 0);
    chk({tag, "_rd_valid"}, 32'(rd_valid), 0);
    chk({tag, "_wr_en"},    32'(iic_wr_en), 0);
    chk({tag, "_rd_en"},    32'(iic_rd_en), 0);
    chk({tag, "_err_cnt"},  32'(err_cnt), 0);
    chk({tag, "_rd_byte"},  32'(rd_byte), 0);
    chk({tag, "_word_add"}, 32'(iic_word_add), 0);
    chk({tag, "_wr_data"},  32'(iic_wr_data), 0);
    chk({tag, "_add_bit"},  32'(iic_add_bit), 1);
  endtask

  // Called at a negedge with the DUT idle; returns at the negedge after done.
  task automatic run(input logic [7:0] s, input bit wp_i, input int extra_off, input bit coincide);
    logic [7:0] exp_rd [N];
    int exp_err, sc, dcyc, busy_bad;
    bit got_done;
    clear_log();
    wp = wp_i;
    exp_err = 0;
    for (int i = 0; i < N; i++) begin
      exp_rd[i] = (wp_i ? 8'hFF : 8'(s + i)) ^ flip[i];
      if (exp_rd[i] != 8'(s + i)) exp_err++;
    end
    start = 1'b1;
    seed  = s;
    @(negedge sys_clk);
    start = 1'b0;
    seed  = 8'($urandom);
    sc = cyc;
    chk("busy_rise", 32'(busy), 1);
    chk("wr_en_first", 32'(iic_wr_en), 1);
    busy_bad = 0;
    got_done = 1'b0;
    dcyc = -1;
    for (int n = 1; n <= RUN_LEN + 20 && !got_done; n++) begin
      if (n == extra_off) start = 1'b1;
      @(negedge sys_clk);
      start = 1'b0;
      if (done) begin
        got_done = 1'b1;
        dcyc = cyc;
        if (coincide) begin
          start = 1'b1;
          seed  = 8'hA5;
        end
      end else if (busy !== 1'b1) begin
        busy_bad++;
      end
    end
    chk("done_seen", 32'(got_done), 1);
    chk("run_len", 32'(dcyc - sc), 32'(RUN_LEN));
    chk("busy_at_done", 32'(busy), 0);
    chk("busy_during_run", 32'(busy_bad), 0);
    chk("pass", 32'(pass), 32'(exp_err == 0));
    chk("err_cnt", 32'(err_cnt), 32'(exp_err));
    @(negedge sys_clk);
    start = 1'b0;
    chk("busy_after_done", 32'(busy), 0);
    chk("pass_hold", 32'(pass), 32'(exp_err == 0));
    chk("done_count", 32'(done_cyc_q.size()), 1);
    chk("wr_count", 32'(wr_cyc_q.size()), 32'(N));
    if (wr_cyc_q.size() == N) begin
      chk("wr_first_cycle", 32'(wr_cyc_q[0] - sc), 0);
      for (int i = 0; i < N; i++) begin
        chk("wr_addr", 32'(wr_add_q[i]), 32'(16'(BASE + i)));
        chk("wr_data", 32'(wr_dat_q[i]), 32'(8'(s + i)));
        if (i > 0) chk("wr_spacing", 32'(wr_cyc_q[i] - wr_cyc_q[i-1]), 32'(T + W));
      end
    end
    chk("rd_count", 32'(rd_cyc_q.size()), 32'(N));
    chk("rv_count", 32'(rv_cyc_q.size()), 32'(N));
    if (rd_cyc_q.size() == N && rv_cyc_q.size() == N && wr_cyc_q.size() == N) begin
      chk("rd_after_wr", 32'(rd_cyc_q[0] - wr_cyc_q[N-1]), 32'(T + W));
      for (int i = 0; i < N; i++) begin
        chk("rd_addr", 32'(rd_add_q[i]), 32'(16'(BASE + i)));
        chk("rd_byte", 32'(rv_byte_q[i]), 32'(exp_rd[i]));
        chk("rd_latency", 32'(rv_cyc_q[i] - rd_cyc_q[i]), 32'(T));
        if (i > 0) chk("rd_spacing", 32'(rd_cyc_q[i] - rd_cyc_q[i-1]), 32'(T + 1));
      end
    end
    chk("rd_byte_last", 32'(rd_byte), 32'(exp_rd[N-1]));
    chk("iface_rules", 32'(viol), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int bad;
    for (int i = 0; i < N; i++) flip[i] = 8'h00;

    // Reset held with start toggling: no activity, reset values everywhere.
    bad = 0;
    for (int i = 0; i < 5; i++) begin
      start = ~start;
      @(negedge sys_clk);
      if (iic_wr_en || iic_rd_en || busy || done || rd_valid) bad++;
    end
    chk("rst_activity", 32'(bad), 0);
    check_idle_outputs("rst");
    start   = 1'b0;
    sys_rst = 1'b0;
    @(negedge sys_clk);
    chk("idle_after_rst_busy", 32'(busy), 0);

    run(8'h55, 1'b0, 0, 1'b0);             // nominal
    mem.delete();
    run(8'h55, 1'b1, 0, 1'b0);             // write-protected blank array
    run(8'hFE, 1'b0, 0, 1'b0);             // seed wrap
    run(8'($urandom), 1'b0, 2 * T + W + 2, 1'b0);   // start during WR_TWC of byte 1
    run(8'($urandom), 1'b0, 0, 1'b1);      // start coincident with done
    run(8'($urandom), 1'b0, 0, 1'b0);      // start one cycle after done

    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < N; i++)
        flip[i] = ($urandom_range(0, 2) == 0) ? 8'($urandom_range(1, 255)) : 8'h00;
      run(8'($urandom), 1'b0, 0, 1'b0);
    end
    for (int i = 0; i < N; i++) flip[i] = 8'h00;

    // Reset during RD_TXN of byte 2, then a clean run.
    clear_log();
    wp    = 1'b0;
    start = 1'b1;
    seed  = 8'h3C;
    @(negedge sys_clk);
    start = 1'b0;
    repeat (N * (T + W) + 2 * (T + 1) + 2) @(negedge sys_clk);
    chk("pre_reset_reads", 32'(rv_byte_q.size()), 2);
    chk("pre_reset_busy", 32'(busy), 1);
    sys_rst = 1'b1;
    @(negedge sys_clk);
    check_idle_outputs("midrst");
    sys_rst = 1'b0;
    repeat (T) @(negedge sys_clk);
    chk("post_rst_idle", 32'(busy), 0);
    run(8'($urandom), 1'b0, 0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
